// File: rtl/apb_mmio_bridge_if.sv
`default_nettype none
// ============================================================================
// Module   : apb_mmio_bridge_if
// Brief    : CPU-side MMIO strobe bus plus APB master bus for apb_mmio_bridge.
//            "master" is the bridge's view, "slave" the CPU/peripheral view.
// Revision : 1.0  initial release
// ============================================================================
interface apb_mmio_bridge_if #(
  parameter int NUM_SLAVES = 8,
  parameter int APB_DW     = 32,
  parameter int APB_AW     = 32
);
  // CPU bus
  logic                  bus_en;
  logic [15:0]           addr;
  logic                  we_n;
  logic [7:0]            datao;
  logic [7:0]            datai;
  logic                  hit;
  logic                  irq_n;
  // APB bus
  logic [NUM_SLAVES-1:0] psel;
  logic                  penable;
  logic                  pwrite;
  logic [APB_AW-1:0]     paddr;
  logic [APB_DW-1:0]     pwdata;
  logic                  presetn;
  logic                  pready;
  logic [APB_DW-1:0]     prdata;
  logic                  pslverr;

  modport master (
    input  bus_en, addr, we_n, datao, pready, prdata, pslverr,
    output datai, hit, irq_n, psel, penable, pwrite, paddr, pwdata, presetn
  );

  modport slave (
    output bus_en, addr, we_n, datao, pready, prdata, pslverr,
    input  datai, hit, irq_n, psel, penable, pwrite, paddr, pwdata, presetn
  );
endinterface
`default_nettype wire

// File: rtl/apb_mmio_bridge.sv
`default_nettype none
// ============================================================================
// Module   : apb_mmio_bridge
// Brief    : 16-byte register window on the 8-bit CPU bus that launches single
//            APB transfers (IDLE/SETUP/ACCESS) with wait-states, slave error
//            capture, timeout abort and a done interrupt.
// Revision : 1.0  initial release
// ============================================================================
module apb_mmio_bridge #(
  parameter logic [15:0] BASE_ADDR   = 16'h3C00,
  parameter int          NUM_SLAVES  = 8,
  parameter int          APB_DW      = 32,
  parameter int          APB_AW      = 32,
  parameter int          TIMEOUT_CYC = 255
) (
  input  wire logic          clk,
  input  wire logic          rst,
  apb_mmio_bridge_if.master  bus
);

  localparam int CNT_W = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC + 1);
  // Counter value seen during the last permitted wait cycle.
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT_CYC == 0) ? 0 : TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  state_t state, state_next;

  logic [APB_AW-1:0] paddr_q;
  logic [APB_DW-1:0] pwdata_q;
  logic [APB_DW-1:0] prdata_q;
  logic [3:0]        sel_q;
  logic              write_q;
  logic              irq_en_q;
  logic              presetn_q;
  logic              done_q;
  logic              timeout_q;
  logic              slverr_q;
  logic              pwrite_q;
  logic              irq_n_q;
  logic              hit_q;
  logic [7:0]        datai_q;
  logic [CNT_W-1:0]  cnt;

  logic              hit_now;
  logic              wr;
  logic              rd;
  logic              busy;
  logic [3:0]        off;
  logic              start;
  logic              fin_ok;
  logic              fin_to;
  logic [7:0]        rdata;
  logic [31:0]       paddr_wide;
  logic [31:0]       pwdata_wide;
  logic [31:0]       prdata_wide;
  logic [31:0]       paddr_upd;
  logic [31:0]       pwdata_upd;

  function automatic logic [31:0] put_byte(input logic [31:0] w, input logic [1:0] idx,
                                           input logic [7:0] b);
    logic [31:0] r;
    r = w;
    r[{idx, 3'b000} +: 8] = b;
    return r;
  endfunction

  function automatic logic [7:0] get_byte(input logic [31:0] w, input logic [1:0] idx);
    return w[{idx, 3'b000} +: 8];
  endfunction

  assign hit_now = bus.bus_en && (bus.addr[15:4] == BASE_ADDR[15:4]);
  assign off     = bus.addr[3:0];
  assign wr      = hit_now && !bus.we_n;
  assign rd      = hit_now && bus.we_n;
  assign busy    = (state != IDLE);

  // Registers viewed as 32-bit words so bytes past the configured width read 0
  // and writes to them fall off when narrowed back.
  assign paddr_wide  = 32'(paddr_q);
  assign pwdata_wide = 32'(pwdata_q);
  assign prdata_wide = 32'(prdata_q);
  assign paddr_upd   = put_byte(paddr_wide, off[1:0], bus.datao);
  assign pwdata_upd  = put_byte(pwdata_wide, off[1:0], bus.datao);

  // Transfer FSM state register; rst aborts any transfer in flight.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state decode and transfer start/finish events.
  always_comb begin
    state_next = state;
    start      = 1'b0;
    fin_ok     = 1'b0;
    fin_to     = 1'b0;
    case (state)
      IDLE: begin
        if (wr && (off == 4'hD) && bus.datao[0]) begin
          start      = 1'b1;
          state_next = SETUP;
        end
      end
      SETUP: state_next = ACCESS;
      ACCESS: begin
        if (bus.pready) begin
          fin_ok     = 1'b1;
          state_next = IDLE;
        end else if ((TIMEOUT_CYC != 0) && (cnt == TO_LAST)) begin
          fin_to     = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // CPU-writable configuration; transfer parameters are frozen while busy.
  always_ff @(posedge clk) begin
    if (rst) begin
      paddr_q   <= '0;
      pwdata_q  <= '0;
      sel_q     <= '0;
      write_q   <= 1'b0;
      irq_en_q  <= 1'b0;
      presetn_q <= 1'b0;
    end else if (wr) begin
      if (!busy && (off[3:2] == 2'b00)) paddr_q  <= paddr_upd[APB_AW-1:0];
      if (!busy && (off[3:2] == 2'b01)) pwdata_q <= pwdata_upd[APB_DW-1:0];
      if (!busy && (off == 4'hC))       sel_q    <= bus.datao[3:0];
      if (off == 4'hD) begin
        if (!busy) write_q <= bus.datao[1];
        irq_en_q  <= bus.datao[2];
        presetn_q <= bus.datao[7];
      end
    end
  end

  // Status bits, read capture, direction latch and wait counter; a completion
  // is applied after the W1C so it wins a same-cycle clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
      slverr_q  <= 1'b0;
      prdata_q  <= '0;
      pwrite_q  <= 1'b0;
      cnt       <= '0;
    end else begin
      if (wr && (off == 4'hE)) begin
        if (bus.datao[1]) done_q    <= 1'b0;
        if (bus.datao[2]) timeout_q <= 1'b0;
        if (bus.datao[3]) slverr_q  <= 1'b0;
      end
      if (start) begin
        done_q    <= 1'b0;
        timeout_q <= 1'b0;
        slverr_q  <= 1'b0;
        pwrite_q  <= bus.datao[1];
        cnt       <= '0;
      end else if ((state == ACCESS) && !bus.pready) begin
        cnt <= cnt + 1'b1;
      end
      if (fin_ok) begin
        done_q   <= 1'b1;
        slverr_q <= bus.pslverr;
        if (!pwrite_q) prdata_q <= bus.prdata;
      end
      if (fin_to) begin
        done_q    <= 1'b1;
        timeout_q <= 1'b1;
      end
    end
  end

  // Register-map read mux.
  always_comb begin
    rdata = 8'h00;
    case (off[3:2])
      2'b00: rdata = get_byte(paddr_wide, off[1:0]);
      2'b01: rdata = get_byte(pwdata_wide, off[1:0]);
      2'b10: rdata = get_byte(prdata_wide, off[1:0]);
      default: begin
        case (off[1:0])
          2'b00:   rdata = {4'b0000, sel_q};
          2'b01:   rdata = {presetn_q, 4'b0000, irq_en_q, write_q, 1'b0};
          2'b10:   rdata = {4'b0000, slverr_q, timeout_q, done_q, busy};
          default: rdata = 8'h00;
        endcase
      end
    endcase
  end

  // Registered CPU read response and interrupt.
  always_ff @(posedge clk) begin
    if (rst) begin
      hit_q   <= 1'b0;
      datai_q <= 8'h00;
      irq_n_q <= 1'b1;
    end else begin
      hit_q   <= hit_now;
      irq_n_q <= ~(done_q & irq_en_q);
      if (rd) datai_q <= rdata;
    end
  end

  // One-hot select; an out-of-range index selects nobody.
  for (genvar i = 0; i < NUM_SLAVES; i++) begin : g_psel
    assign bus.psel[i] = busy && (sel_q == 4'(i));
  end

  assign bus.penable = (state == ACCESS);
  assign bus.pwrite  = pwrite_q;
  assign bus.paddr   = paddr_q;
  assign bus.pwdata  = pwdata_q;
  assign bus.presetn = presetn_q;
  assign bus.datai   = datai_q;
  assign bus.hit     = hit_q;
  assign bus.irq_n   = irq_n_q;

endmodule
`default_nettype wire

// File: tb/tb_apb_mmio_bridge.sv
`default_nettype none
// ============================================================================
// Module   : tb_apb_mmio_bridge
// Brief    : Self-checking bench for apb_mmio_bridge with a scripted APB slave
//            and scoreboards for CPU reads and APB transfers.
// Revision : 1.0  initial release
// ============================================================================
module tb_apb_mmio_bridge;

  localparam int NS = 8;
  localparam int DW = 32;
  localparam int AW = 32;
  localparam int TO = 4;
  localparam logic [15:0] B = 16'h3C00;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  apb_mmio_bridge_if #(.NUM_SLAVES(NS), .APB_DW(DW), .APB_AW(AW)) bus ();

  apb_mmio_bridge #(
    .BASE_ADDR(B), .NUM_SLAVES(NS), .APB_DW(DW), .APB_AW(AW), .TIMEOUT_CYC(TO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    string      tag;
    logic [7:0] exp;
    logic       hit;
  } rd_t;

  typedef struct {
    logic [7:0]  psel;
    logic        pwrite;
    logic [31:0] paddr;
    logic [31:0] pwdata;
  } xf_t;

  rd_t rdq[$];
  xf_t xq[$];

  int checks   = 0;
  int failures = 0;

  // Slave behaviour knobs and activity counters.
  int          wait_states = 0;
  bit          hang        = 1'b0;
  logic [31:0] rdata_cfg   = 32'h0;
  logic        err_cfg     = 1'b0;
  int          acc_cnt     = 0;
  int          sel_cycles  = 0;
  int          en_cycles   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic cpu_wr(input logic [15:0] a, input logic [7:0] d);
    bus.bus_en = 1'b1;
    bus.addr   = a;
    bus.we_n   = 1'b0;
    bus.datao  = d;
    @(negedge clk);
    bus.bus_en = 1'b0;
    bus.we_n   = 1'b1;
  endtask

  task automatic cpu_rd(input logic [15:0] a, input string tag, input logic [7:0] exp,
                        input logic exp_hit);
    rd_t r;
    rdq.push_back('{tag: tag, exp: exp, hit: exp_hit});
    bus.bus_en = 1'b1;
    bus.addr   = a;
    bus.we_n   = 1'b1;
    @(negedge clk);
    bus.bus_en = 1'b0;
    r = rdq.pop_front();
    check({r.tag, "_hit"}, 32'(bus.hit), 32'(r.hit));
    check(r.tag, 32'(bus.datai), 32'(r.exp));
  endtask

  // Counts clocks from the START edge until penable has risen and fallen.
  task automatic wait_done(output int k);
    bit seen;
    seen = 1'b0;
    k    = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      k++;
      if (bus.penable) seen = 1'b1;
      else if (seen) break;
    end
  endtask

  task automatic clr_counts();
    sel_cycles = 0;
    en_cycles  = 0;
  endtask

  // APB slave: answers only when selected, after wait_states ACCESS cycles.
  initial begin
    xf_t x;
    bus.pready  = 1'b0;
    bus.prdata  = '0;
    bus.pslverr = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.psel != '0) sel_cycles++;
      if (bus.penable) en_cycles++;
      if (bus.penable && (bus.psel != '0)) begin
        if (!hang && (acc_cnt == wait_states)) begin
          bus.pready  = 1'b1;
          bus.prdata  = rdata_cfg;
          bus.pslverr = err_cfg;
          check("apb_pending_empty", 32'(xq.size() == 0), 32'd0);
          if (xq.size() != 0) begin
            x = xq.pop_front();
            check("apb_psel",   32'(bus.psel),   32'(x.psel));
            check("apb_pwrite", 32'(bus.pwrite), 32'(x.pwrite));
            check("apb_paddr",  bus.paddr,       x.paddr);
            check("apb_pwdata", bus.pwdata,      x.pwdata);
          end
        end else begin
          bus.pready = 1'b0;
        end
        acc_cnt++;
      end else begin
        bus.pready  = 1'b0;
        bus.pslverr = 1'b0;
        acc_cnt     = 0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "watchdog");
  end

  // Directed sequence.
  initial begin
    int k;
    rst        = 1'b1;
    bus.bus_en = 1'b0;
    bus.addr   = '0;
    bus.we_n   = 1'b1;
    bus.datao  = '0;
    repeat (3) @(negedge clk);
    check("rst_psel",    32'(bus.psel),    32'd0);
    check("rst_penable", 32'(bus.penable), 32'd0);
    check("rst_pwrite",  32'(bus.pwrite),  32'd0);
    check("rst_paddr",   bus.paddr,        32'd0);
    check("rst_pwdata",  bus.pwdata,       32'd0);
    check("rst_presetn", 32'(bus.presetn), 32'd0);
    check("rst_irq_n",   32'(bus.irq_n),   32'd1);
    check("rst_hit",     32'(bus.hit),     32'd0);
    check("rst_datai",   32'(bus.datai),   32'd0);
    rst = 1'b0;
    cpu_rd(B + 16'hE, "rst_status", 8'h00, 1'b1);

    // Write transfer, zero wait states.
    cpu_wr(B + 16'h0, 8'h34); cpu_wr(B + 16'h1, 8'h12);
    cpu_wr(B + 16'h2, 8'h00); cpu_wr(B + 16'h3, 8'h00);
    cpu_wr(B + 16'h4, 8'hEF); cpu_wr(B + 16'h5, 8'hBE);
    cpu_wr(B + 16'h6, 8'hAD); cpu_wr(B + 16'h7, 8'hDE);
    cpu_wr(B + 16'hC, 8'h02);
    check("t1_paddr",  bus.paddr,  32'h0000_1234);
    check("t1_pwdata", bus.pwdata, 32'hDEAD_BEEF);
    cpu_rd(B + 16'h0, "t1_paddr_b0", 8'h34, 1'b1);
    wait_states = 0; hang = 1'b0; err_cfg = 1'b0;
    xq.push_back('{psel: 8'h04, pwrite: 1'b1, paddr: 32'h1234, pwdata: 32'hDEAD_BEEF});
    clr_counts();
    cpu_wr(B + 16'hD, 8'h83);
    wait_done(k);
    check("t1_latency", 32'(k), 32'd2);
    @(negedge clk);
    check("t1_sel_cycles", 32'(sel_cycles), 32'd2);
    check("t1_en_cycles",  32'(en_cycles),  32'd1);
    check("t1_presetn",    32'(bus.presetn), 32'd1);
    check("t1_irq_n",      32'(bus.irq_n),   32'd1);
    cpu_rd(B + 16'hE, "t1_status", 8'h02, 1'b1);
    cpu_rd(B + 16'hD, "t1_ctrl",   8'h82, 1'b1);

    // Read transfer with three wait states.
    cpu_wr(B + 16'hC, 8'h00);
    wait_states = 3; rdata_cfg = 32'hCAFE_F00D;
    xq.push_back('{psel: 8'h01, pwrite: 1'b0, paddr: 32'h1234, pwdata: 32'hDEAD_BEEF});
    clr_counts();
    cpu_wr(B + 16'hD, 8'h81);
    wait_done(k);
    check("t2_latency", 32'(k), 32'd5);
    @(negedge clk);
    check("t2_en_cycles", 32'(en_cycles), 32'd4);
    cpu_rd(B + 16'h8, "t2_prdata_b0", 8'h0D, 1'b1);
    cpu_rd(B + 16'h9, "t2_prdata_b1", 8'hF0, 1'b1);
    cpu_rd(B + 16'hA, "t2_prdata_b2", 8'hFE, 1'b1);
    cpu_rd(B + 16'hB, "t2_prdata_b3", 8'hCA, 1'b1);
    cpu_rd(B + 16'hE, "t2_status",    8'h02, 1'b1);

    // Slave never ready: timeout after TO access cycles.
    hang = 1'b1; rdata_cfg = 32'h1111_1111;
    clr_counts();
    cpu_wr(B + 16'hD, 8'h81);
    wait_done(k);
    check("t3_latency", 32'(k), 32'd5);
    @(negedge clk);
    check("t3_en_cycles", 32'(en_cycles), 32'd4);
    check("t3_psel",      32'(bus.psel),  32'd0);
    cpu_rd(B + 16'hE, "t3_status",    8'h06, 1'b1);
    cpu_rd(B + 16'h8, "t3_prdata_b0", 8'h0D, 1'b1);

    // Slave error with interrupt enabled.
    hang = 1'b0; wait_states = 0; err_cfg = 1'b1;
    xq.push_back('{psel: 8'h01, pwrite: 1'b1, paddr: 32'h1234, pwdata: 32'hDEAD_BEEF});
    cpu_wr(B + 16'hD, 8'h87);
    wait_done(k);
    check("t4_latency",   32'(k),         32'd2);
    check("t4_irq_n_now", 32'(bus.irq_n), 32'd1);
    @(posedge clk); #1;
    check("t4_irq_n_low", 32'(bus.irq_n), 32'd0);
    @(negedge clk);
    err_cfg = 1'b0;
    cpu_rd(B + 16'hE, "t4_status", 8'h0A, 1'b1);
    cpu_wr(B + 16'hE, 8'h02);
    check("t4_irq_n_hold", 32'(bus.irq_n), 32'd0);
    @(posedge clk); #1;
    check("t4_irq_n_high", 32'(bus.irq_n), 32'd1);
    @(negedge clk);
    cpu_rd(B + 16'hE, "t4_status_w1c", 8'h08, 1'b1);

    // Writes while busy are ignored; rst in ACCESS aborts.
    hang = 1'b1;
    cpu_wr(B + 16'hD, 8'h81);
    cpu_wr(B + 16'h0, 8'h55);
    cpu_wr(B + 16'hD, 8'h83);
    check("t5_paddr",   bus.paddr,          32'h0000_1234);
    check("t5_pwrite",  32'(bus.pwrite),    32'd0);
    check("t5_penable", 32'(bus.penable),   32'd1);
    check("t5_psel",    32'(bus.psel),      32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("t5_rst_psel",    32'(bus.psel),    32'd0);
    check("t5_rst_penable", 32'(bus.penable), 32'd0);
    check("t5_rst_presetn", 32'(bus.presetn), 32'd0);
    hang = 1'b0;
    cpu_rd(B + 16'hE, "t5_status", 8'h00, 1'b1);
    check("t5_idle_penable", 32'(bus.penable), 32'd0);

    // Out-of-window read and out-of-range slave index.
    cpu_wr(B + 16'hC, 8'h09);
    cpu_rd(B + 16'hC, "t6_sel", 8'h09, 1'b1);
    cpu_rd(16'h3C1C, "t6_outside", 8'h09, 1'b0);
    clr_counts();
    cpu_wr(B + 16'hD, 8'h81);
    wait_done(k);
    check("t6_latency", 32'(k), 32'd5);
    @(negedge clk);
    check("t6_sel_cycles", 32'(sel_cycles), 32'd0);
    check("t6_en_cycles",  32'(en_cycles),  32'd4);
    cpu_rd(B + 16'hE, "t6_status", 8'h06, 1'b1);

    check("apb_left_over", 32'(xq.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/apb_mmio_bridge.md
Name: apb_mmio_bridge

Overview:
- Parametrised successor to the fixed-slot MMIO window in the memory block.
- Exposes a byte-addressed register window on the 8-bit CPU bus. A CPU-launched APB transfer runs through a proper IDLE/SETUP/ACCESS master FSM.
- Adds the following, none of which the previous block had:
  - configurable slave count and data width
  - pready wait-states
  - pslverr capture
  - timeout abort
  - done interrupt

Parameters:
- BASE_ADDR, 16'h3C00: window base; the window is 16 bytes, so BASE_ADDR[3:0] must be 0.
- NUM_SLAVES, 8: width of psel (one-hot), 1..16.
- APB_DW, 32: APB data width, 8/16/32; holds are APB_DW/8 bytes.
- APB_AW, 32: APB address width, 8..32.
- TIMEOUT_CYC, 255: ACCESS-phase clk cycles before abort; 0 disables the timeout.

Ports:
- clk  in  1  bridge clock (clk_div4 domain)
- rst  in  1  synchronous, active-high reset
- bus_en  in  1  one-cycle strobe qualifying addr/we_n/datao
- addr  in  16  CPU address
- we_n  in  1  1=read, 0=write
- datao  in  8  CPU write data
- datai  out  8  CPU read data (registered)
- hit  out  1  registered; the access decoded into the window
- irq_n  out  1  active-low interrupt
- psel  out  NUM_SLAVES  one-hot APB select
- penable  out  1  APB enable
- pwrite  out  1  APB direction
- paddr  out  APB_AW  APB address
- pwdata  out  APB_DW  APB write data
- presetn  out  1  APB reset (software controlled)
- pready  in  1  APB ready
- prdata  in  APB_DW  APB read data
- pslverr  in  1  APB slave error

Behaviour:
- Register map (offset = addr[3:0]; multi-byte fields are little-endian; bytes beyond APB_DW/8 or APB_AW/8 read 0 and ignore writes):
  - 0x0-0x3 PADDR (RW)
  - 0x4-0x7 PWDATA (RW)
  - 0x8-0xB PRDATA (RO)
  - 0xC SEL[3:0] (RW): slave index
  - 0xD CTRL (RW):
    - b0 START: write-1, self-clearing, reads 0
    - b1 WRITE
    - b2 IRQ_EN
    - b7 PRESETN
  - 0xE STATUS:
    - b0 BUSY (RO)
    - b1 DONE (W1C)
    - b2 TIMEOUT (W1C)
    - b3 SLVERR (W1C)
  - 0xF reads 0.
- Decode: hit_now = bus_en & (addr[15:4] == BASE_ADDR[15:4]).
- CPU write: takes effect on the clk edge with hit_now & ~we_n.
- CPU read: datai/hit are valid one clk after the strobe.
  - datai holds its last value when there is no hit.
  - hit=0 when there is no strobe or no decode.
- Reset values:
  - all registers, datai, hit: 0
  - psel, penable, pwrite, paddr, pwdata: 0
  - presetn = 0, since CTRL.b7 resets to 0
  - irq_n = 1
  - FSM in IDLE
- FSM:
  - IDLE: a CPU write to CTRL with b0=1 goes to SETUP.
    - Clears DONE, TIMEOUT and SLVERR in the same edge.
    - Latches pwrite = WRITE.
    - Sets psel = 1<<SEL; a SEL >= NUM_SLAVES gives psel = 0, but the transfer still runs and times out.
  - SETUP (one cycle): psel set, penable = 0; next state is ACCESS.
  - ACCESS: penable = 1.
    - If pready: on reads, capture prdata into PRDATA; SLVERR = pslverr; DONE = 1; return to IDLE with psel = 0 and penable = 0.
    - Otherwise the timeout counter increments. If the count reaches TIMEOUT_CYC (and TIMEOUT_CYC != 0): DONE = 1, TIMEOUT = 1, PRDATA unchanged, go to IDLE.
  - Minimum transfer is 2 clks: START edge to the DONE-set edge inclusive of the SETUP and ACCESS cycles.
- Stability: while BUSY (SETUP or ACCESS), CPU writes to PADDR, PWDATA, SEL and CTRL.b0/b1 are ignored. paddr and pwdata are driven directly from the registers, so they stay stable. CTRL.b2/b7 remain writable.
- BUSY = (state != IDLE).
- irq_n = ~(DONE & IRQ_EN), registered; it follows DONE one clk later.
- Simultaneous W1C of DONE and a completion in the same cycle: completion wins (DONE = 1).
- Synchronous rst mid-transfer: returns the FSM to IDLE, drops psel/penable immediately on that edge, and clears all status bits.

Test Plan:
- Write PADDR=0x0000_1234, PWDATA=0xDEAD_BEEF, SEL=2, CTRL=0x83; slave pready on the first ACCESS cycle -> psel=0x04 for 2 clks, penable high 1 clk, pwrite=1, STATUS reads 0x02.
- Read transfer with CTRL=0x81 to SEL=0, slave inserts 3 wait states then returns prdata=0xCAFE_F00D -> PRDATA bytes 0x8-0xB read 0D,F0,FE,CA; DONE=1 after 5 clks.
- pready never asserted, TIMEOUT_CYC=4 -> abort after 4 ACCESS cycles, STATUS=0x06, psel=0.
- pslverr=1 with pready, IRQ_EN=1 -> STATUS=0x0A; irq_n low 1 clk after DONE; writing 0x02 to STATUS raises irq_n.
- Write PADDR byte 0 while BUSY, and issue START while BUSY -> paddr unchanged and no second transfer; assert rst in ACCESS -> psel=0, penable=0, STATUS=0x00 on the next edge.
- Read at addr 0x3C1C (outside the window), then SEL=9 with NUM_SLAVES=8 -> hit=0; psel stays 0 and TIMEOUT is set.
